// File: rtl/reg_wb_pkg.sv
// +----------------------------------------------------------------------+
// | reg_wb_pkg : shared types and defaults for the write-back arbiter     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package reg_wb_pkg;

  localparam int DEFAULT_AW = 5;
  localparam int DEFAULT_DW = 32;
  localparam int REG_ZERO   = 0;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } wb_state_e;

endpackage

`default_nettype wire

// File: rtl/reg_wb_arbiter_rr.sv
// +----------------------------------------------------------------------+
// | rr_arbiter : combinational round-robin pick starting after ptr        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module rr_arbiter
  import reg_wb_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [PW-1:0]   grant_idx,
  output logic            grant_any
);

  logic [PW:0]   w_sum;
  logic [PW-1:0] w_cand;

  // ptr is always < NREQ, so one conditional subtract implements the wrap.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    w_sum     = '0;
    w_cand    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_sum = {1'b0, ptr} + (PW+1)'(k);
      if (w_sum >= (PW+1)'(NREQ))
        w_sum = w_sum - (PW+1)'(NREQ);
      w_cand = w_sum[PW-1:0];
      if (!grant_any && req[w_cand]) begin
        grant_any      = 1'b1;
        grant[w_cand]  = 1'b1;
        grant_idx      = w_cand;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/reg_wb_arbiter.sv
// +----------------------------------------------------------------------+
// | reg_wb_arbiter : round-robin write-back port sharing with drain       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module reg_wb_arbiter
  import reg_wb_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int AW   = DEFAULT_AW,
  parameter int DW   = DEFAULT_DW,
  parameter int CW   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic             wr_valid,
  input  logic             wr_ready,
  output logic [AW-1:0]    wr_addr,
  output logic [DW-1:0]    wr_data,
  input  logic             drain_req,
  output logic             drain_done,
  output logic [CW-1:0]    wr_count
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  wb_state_e     r_state;
  wb_state_e     w_state_nxt;
  logic [PW-1:0] r_ptr;
  logic          r_wr_valid;
  logic [AW-1:0] r_wr_addr;
  logic [DW-1:0] r_wr_data;
  logic [CW-1:0] r_wr_count;

  logic [NREQ-1:0] w_grant;
  logic [PW-1:0]   w_grant_idx;
  logic            w_grant_any;
  logic            w_stage_free;
  logic            w_grant_en;
  logic            w_drain_done;
  logic            w_take;
  logic            w_load;
  logic [AW-1:0]   w_sel_addr;
  logic [DW-1:0]   w_sel_data;

  rr_arbiter #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_rr (
    .req       (req_valid),
    .ptr       (r_ptr),
    .grant     (w_grant),
    .grant_idx (w_grant_idx),
    .grant_any (w_grant_any)
  );

  assign w_stage_free = !r_wr_valid || wr_ready;
  assign w_sel_addr   = req_addr[w_grant_idx*AW +: AW];
  assign w_sel_data   = req_data[w_grant_idx*DW +: DW];
  assign w_take       = w_grant_en && w_grant_any;
  // Writes to register 0 are accepted but never reach the register file.
  assign w_load       = w_take && (w_sel_addr != AW'(REG_ZERO));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= ST_RUN;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:    if (drain_req) w_state_nxt = ST_DRAIN;
      ST_DRAIN: begin
        // No refill happens here, so a committing stage counts as empty.
        if (!r_wr_valid || wr_ready) w_state_nxt = ST_HALTED;
        else if (!drain_req)         w_state_nxt = ST_RUN;
      end
      ST_HALTED: if (!drain_req) w_state_nxt = ST_RUN;
      default:   w_state_nxt = ST_RUN;
    endcase
  end

  // drain_req blocks grants combinationally, before the state changes.
  always_comb begin
    w_grant_en   = 1'b0;
    w_drain_done = 1'b0;
    case (r_state)
      ST_RUN:    w_grant_en   = !drain_req && w_stage_free;
      ST_HALTED: w_drain_done = 1'b1;
      default:   ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr      <= PW'(NREQ-1);
      r_wr_valid <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_wr_count <= '0;
    end else begin
      if (w_take)
        r_ptr <= w_grant_idx;
      if (w_load) begin
        r_wr_valid <= 1'b1;
        r_wr_addr  <= w_sel_addr;
        r_wr_data  <= w_sel_data;
      end else if (wr_ready) begin
        r_wr_valid <= 1'b0;
      end
      if (r_wr_valid && wr_ready)
        r_wr_count <= r_wr_count + CW'(1);
    end
  end

  assign req_ready  = w_grant_en ? w_grant : '0;
  assign wr_valid   = r_wr_valid;
  assign wr_addr    = r_wr_addr;
  assign wr_data    = r_wr_data;
  assign wr_count   = r_wr_count;
  assign drain_done = w_drain_done;

endmodule

`default_nettype wire

// File: tb/tb_reg_wb_arbiter.sv
// +----------------------------------------------------------------------+
// | tb_reg_wb_arbiter : directed self-checking bench for reg_wb_arbiter   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_reg_wb_arbiter;

  localparam int NREQ = 3;
  localparam int AW   = 5;
  localparam int DW   = 32;
  localparam int CW   = 16;

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic              wr_valid;
  logic              wr_ready;
  logic [AW-1:0]     wr_addr;
  logic [DW-1:0]     wr_data;
  logic              drain_req;
  logic              drain_done;
  logic [CW-1:0]     wr_count;

  int total;
  int bad;

  reg_wb_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .CW(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .drain_req  (drain_req),
    .drain_done (drain_done),
    .wr_count   (wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = '0; req_addr = '0; req_data = '0;
    wr_ready = 1'b0; drain_req = 1'b0;
    #12;
    total++; if (wr_valid !== 1'b0) begin bad++; $display("FAIL reset_wr_valid: got %0h want 0", wr_valid); end
    total++; if (wr_addr !== '0) begin bad++; $display("FAIL reset_wr_addr: got %0h want 0", wr_addr); end
    total++; if (wr_data !== '0) begin bad++; $display("FAIL reset_wr_data: got %0h want 0", wr_data); end
    total++; if (wr_count !== '0) begin bad++; $display("FAIL reset_wr_count: got %0h want 0", wr_count); end
    total++; if (drain_done !== 1'b0) begin bad++; $display("FAIL reset_drain_done: got %0h want 0", drain_done); end
    total++; if (req_ready !== 3'b000) begin bad++; $display("FAIL reset_req_ready: got %0b want 000", req_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_fairness();
    int order [6] = '{0, 1, 2, 0, 1, 2};
    for (int i = 0; i < NREQ; i++) set_req(i, AW'(5 + i), DW'(32'h100 + i));
    req_valid = 3'b111; wr_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      total++; if (req_ready !== 3'(1 << order[k])) begin bad++; $display("FAIL fair_grant%0d: got %0b want %0b", k, req_ready, 3'(1 << order[k])); end
      tick();
      total++; if (wr_valid !== 1'b1 || wr_addr !== AW'(5 + order[k])) begin bad++; $display("FAIL fair_out%0d: got v=%0h a=%0d want v=1 a=%0d", k, wr_valid, wr_addr, 5 + order[k]); end
    end
    req_valid = '0;
    tick();
    total++; if (wr_count !== 16'd6) begin bad++; $display("FAIL fair_count: got %0d want 6", wr_count); end
  endtask

  task automatic test_single();
    set_req(0, 5'd9, 32'hDEAD_BEEF);
    req_valid = 3'b001; wr_ready = 1'b1;
    #1;
    total++; if (req_ready !== 3'b001) begin bad++; $display("FAIL single_ready: got %0b want 001", req_ready); end
    tick();
    req_valid = '0;
    total++; if (wr_valid !== 1'b1 || wr_addr !== 5'd9 || wr_data !== 32'hDEAD_BEEF) begin bad++; $display("FAIL single_out: got v=%0h a=%0d d=%0h want v=1 a=9 d=deadbeef", wr_valid, wr_addr, wr_data); end
    tick();
    total++; if (wr_count !== 16'd7 || wr_valid !== 1'b0) begin bad++; $display("FAIL single_commit: got cnt=%0d v=%0h want cnt=7 v=0", wr_count, wr_valid); end
  endtask

  task automatic test_backpressure();
    set_req(1, 5'd20, 32'h0000_A5A5);
    req_valid = 3'b010; wr_ready = 1'b1;
    #1;
    total++; if (req_ready !== 3'b010) begin bad++; $display("FAIL bp_first_ready: got %0b want 010", req_ready); end
    tick();
    set_req(0, 5'd3, 32'h33);
    set_req(2, 5'd4, 32'h44);
    req_valid = 3'b101; wr_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      total++; if (req_ready !== 3'b000 || wr_valid !== 1'b1 || wr_addr !== 5'd20 || wr_data !== 32'hA5A5) begin bad++; $display("FAIL bp_hold%0d: got r=%0b v=%0h a=%0d d=%0h want r=000 v=1 a=20 d=a5a5", k, req_ready, wr_valid, wr_addr, wr_data); end
      tick();
    end
    wr_ready = 1'b1;
    #1;
    total++; if (req_ready !== 3'b100) begin bad++; $display("FAIL bp_release_ready: got %0b want 100", req_ready); end
    tick();
    req_valid = '0;
    total++; if (wr_addr !== 5'd4 || wr_count !== 16'd8) begin bad++; $display("FAIL bp_refill: got a=%0d cnt=%0d want a=4 cnt=8", wr_addr, wr_count); end
    tick();
    total++; if (wr_count !== 16'd9 || wr_valid !== 1'b0) begin bad++; $display("FAIL bp_count: got cnt=%0d v=%0h want cnt=9 v=0", wr_count, wr_valid); end
  endtask

  task automatic test_regzero();
    set_req(1, 5'd0, 32'h1111);
    req_valid = 3'b010; wr_ready = 1'b1;
    #1;
    total++; if (req_ready !== 3'b010) begin bad++; $display("FAIL rz_ready0: got %0b want 010", req_ready); end
    tick();
    total++; if (wr_valid !== 1'b0) begin bad++; $display("FAIL rz_dropped: got v=%0h want 0", wr_valid); end
    set_req(1, 5'd12, 32'h0C0C);
    #1;
    total++; if (req_ready !== 3'b010) begin bad++; $display("FAIL rz_ready12: got %0b want 010", req_ready); end
    tick();
    req_valid = '0;
    total++; if (wr_valid !== 1'b1 || wr_addr !== 5'd12) begin bad++; $display("FAIL rz_out: got v=%0h a=%0d want v=1 a=12", wr_valid, wr_addr); end
    tick();
    total++; if (wr_count !== 16'd10) begin bad++; $display("FAIL rz_count: got %0d want 10", wr_count); end
  endtask

  task automatic test_drain();
    set_req(0, 5'd7, 32'h77);
    req_valid = 3'b001; wr_ready = 1'b1;
    #1;
    total++; if (req_ready !== 3'b001) begin bad++; $display("FAIL dr_load_ready: got %0b want 001", req_ready); end
    tick();
    set_req(2, 5'd4, 32'h44);
    req_valid = 3'b100; wr_ready = 1'b0; drain_req = 1'b1;
    #1;
    total++; if (req_ready !== 3'b000) begin bad++; $display("FAIL dr_ready_c0: got %0b want 000", req_ready); end
    tick();
    total++; if (req_ready !== 3'b000 || drain_done !== 1'b0 || wr_valid !== 1'b1) begin bad++; $display("FAIL dr_c1: got r=%0b dd=%0h v=%0h want r=000 dd=0 v=1", req_ready, drain_done, wr_valid); end
    tick();
    wr_ready = 1'b1;
    #1;
    total++; if (req_ready !== 3'b000) begin bad++; $display("FAIL dr_ready_c2: got %0b want 000", req_ready); end
    tick();
    total++; if (drain_done !== 1'b1 || wr_valid !== 1'b0 || wr_count !== 16'd11) begin bad++; $display("FAIL dr_done: got dd=%0h v=%0h cnt=%0d want dd=1 v=0 cnt=11", drain_done, wr_valid, wr_count); end
    tick();
    total++; if (drain_done !== 1'b1 || req_ready !== 3'b000) begin bad++; $display("FAIL dr_halted: got dd=%0h r=%0b want dd=1 r=000", drain_done, req_ready); end
    drain_req = 1'b0;
    #1;
    total++; if (req_ready !== 3'b000) begin bad++; $display("FAIL dr_release_ready: got %0b want 000", req_ready); end
    tick();
    total++; if (drain_done !== 1'b0 || req_ready !== 3'b100) begin bad++; $display("FAIL dr_resume: got dd=%0h r=%0b want dd=0 r=100", drain_done, req_ready); end
    tick();
    req_valid = '0;
    total++; if (wr_valid !== 1'b1 || wr_addr !== 5'd4) begin bad++; $display("FAIL dr_resume_out: got v=%0h a=%0d want v=1 a=4", wr_valid, wr_addr); end
    tick();
    total++; if (wr_count !== 16'd12) begin bad++; $display("FAIL dr_count: got %0d want 12", wr_count); end
  endtask

  task automatic test_midreset();
    set_req(1, 5'd9, 32'h1);
    req_valid = 3'b010; wr_ready = 1'b1;
    #1;
    total++; if (req_ready !== 3'b010) begin bad++; $display("FAIL mr_ready: got %0b want 010", req_ready); end
    tick();
    req_valid = '0; wr_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (wr_valid !== 1'b0 || wr_count !== '0) begin bad++; $display("FAIL mr_async: got v=%0h cnt=%0d want v=0 cnt=0", wr_valid, wr_count); end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    set_req(0, 5'd5, 32'h100);
    req_valid = 3'b111; wr_ready = 1'b1;
    #1;
    total++; if (req_ready !== 3'b001) begin bad++; $display("FAIL mr_first_grant: got %0b want 001", req_ready); end
    tick();
    req_valid = '0;
    total++; if (wr_valid !== 1'b1 || wr_addr !== 5'd5 || wr_count !== '0) begin bad++; $display("FAIL mr_out: got v=%0h a=%0d cnt=%0d want v=1 a=5 cnt=0", wr_valid, wr_addr, wr_count); end
    tick();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_fairness();
    test_single();
    test_backpressure();
    test_regzero();
    test_drain();
    test_midreset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
